systolic_seq_ctrl: RTL

Wishbone-controlled sequencer for the 3x3 weight-stationary systolic array. Firmware loads weights through the weight-register block, writes a column count, then writes START. The block pulses the array clear and weight-latch, streams activation columns out of the activation buffer, drains the pipeline, captures results, and raises done/irq. It sits between the Wishbone bus and the array/activation-buffer datapath.

---
 rtl/systolic_seq_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/systolic_seq_ctrl.sv
// Wishbone-controlled sequencer for the 3x3 weight-stationary systolic array.
// Optional busy-cycle counter on the CYCLES register: define SYSTOLIC_PERF_CNT_EN.
module systolic_seq_ctrl #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0100,
  parameter int          ARRAY_SIZE   = 3,
  parameter int          ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [31:0]       wb_adr_i,
  output logic              wb_ack_o,
  output logic [31:0]       wb_dat_o,
  output logic              arr_clr,
  output logic              w_load,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  output logic              arr_en,
  output logic              res_capture,
  output logic              irq
);

  localparam int DRAIN_LEN = 2 * ARRAY_SIZE;
  localparam int DCNT_W    = $clog2(DRAIN_LEN + 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOADW  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic              r_ack;
  logic [ADDR_W-1:0] r_numCols;
  logic [ADDR_W-1:0] r_addr;
  logic [DCNT_W-1:0] r_drainCnt;
  logic              r_done;
  logic              r_err;
  logic              r_actRdEnD;

  logic        w_sel;
  logic        w_wr;
  logic        w_ctrlWr;
  logic        w_numWr;
  logic        w_start;
  logic        w_abort;
  logic        w_clrDone;
  logic        w_busy;
  logic        w_accept;
  logic        w_startErr;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic [31:0] w_cycles;
  logic        w_unused;

  // Register writes land on the ack cycle, while the master still holds the strobe.
  assign w_sel      = wb_stb_i & wb_cyc_i & (wb_adr_i[31:4] == BASE_ADDRESS[31:4]);
  assign w_wr       = r_ack & w_sel & wb_we_i;
  assign w_ctrlWr   = w_wr & (wb_adr_i[3:2] == 2'd0);
  assign w_numWr    = w_wr & (wb_adr_i[3:2] == 2'd2);
  assign w_start    = w_ctrlWr & wb_dat_i[0];
  assign w_abort    = w_ctrlWr & wb_dat_i[1];
  assign w_clrDone  = w_ctrlWr & wb_dat_i[2];
  assign w_busy     = (r_state != S_IDLE);
  assign w_accept   = (r_state == S_IDLE) & w_start & ~w_abort & (r_numCols != '0);
  assign w_startErr = (r_state == S_IDLE) & w_start & ~w_abort & (r_numCols == '0);
  assign w_unused   = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[31:ADDR_W]};

  always_ff @(posedge clk) begin
    if (rst) r_ack <= 1'b0;
    else     r_ack <= w_sel & ~r_ack;
  end

  assign w_status = {21'd0, r_state, 5'd0, r_err, r_done, w_busy};

  always_comb begin
    w_rdata = '0;
    case (wb_adr_i[3:2])
      2'd1:    w_rdata = w_status;
      2'd2:    w_rdata = 32'(r_numCols);
      2'd3:    w_rdata = w_cycles;
      default: w_rdata = '0;
    endcase
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_ack ? w_rdata : '0;

`ifdef SYSTOLIC_PERF_CNT_EN
  logic [31:0] r_cycles;

  always_ff @(posedge clk) begin
    if (rst)                                     r_cycles <= '0;
    else if (w_accept)                           r_cycles <= '0;
    else if (w_busy && r_cycles != 32'hFFFF_FFFF) r_cycles <= r_cycles + 32'd1;
  end

  assign w_cycles = r_cycles;
`else
  assign w_cycles = '0;
`endif

  always_comb begin
    w_stateNext = r_state;
    arr_clr     = 1'b0;
    w_load      = 1'b0;
    act_rd_en   = 1'b0;
    res_capture = 1'b0;
    case (r_state)
      S_IDLE:   if (w_accept) w_stateNext = S_CLEAR;
      S_CLEAR:  begin
        arr_clr     = 1'b1;
        w_stateNext = S_LOADW;
      end
      S_LOADW:  begin
        w_load      = 1'b1;
        w_stateNext = S_STREAM;
      end
      S_STREAM: begin
        act_rd_en = 1'b1;
        if (r_addr == r_numCols - ADDR_W'(1)) w_stateNext = S_DRAIN;
      end
      S_DRAIN:  if (r_drainCnt == DRAIN_LAST) w_stateNext = S_DONE;
      S_DONE:   begin
        res_capture = 1'b1;
        w_stateNext = S_IDLE;
      end
      default:  w_stateNext = S_IDLE;
    endcase
    if (w_abort && w_busy) w_stateNext = S_IDLE;
  end

  // The delayed read enable is dropped on abort so arr_en falls with the other strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_actRdEnD <= 1'b0;
      r_addr     <= '0;
      r_drainCnt <= '0;
      r_numCols  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_actRdEnD <= act_rd_en & (w_stateNext != S_IDLE);
      if (r_state == S_LOADW && w_stateNext == S_STREAM)
        r_addr <= '0;
      else if (r_state == S_STREAM && w_stateNext == S_STREAM)
        r_addr <= r_addr + ADDR_W'(1);
      r_drainCnt <= (r_state == S_DRAIN) ? r_drainCnt + DCNT_W'(1) : '0;
      if (w_numWr && !w_busy) r_numCols <= wb_dat_i[ADDR_W-1:0];
      if (w_startErr) r_err <= 1'b1;
      if (w_accept || w_clrDone)
        r_done <= 1'b0;
      else if (r_state == S_DONE && !w_abort)
        r_done <= 1'b1;
    end
  end

  assign act_rd_addr = r_addr;
  assign arr_en      = r_actRdEnD | (r_state == S_DRAIN);
  assign irq         = r_done;

endmodule
